// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares one data-memory/IO bridge between instruction fetch and load/store.
// At most one access is granted per cycle. Data wins by default. Fetch wins
// once it has been denied STARVE_MAX cycles in a row. In-flight reads are
// tracked by a fixed-latency tag pipeline, so returning data is routed to
// the requester that issued the read. Nothing is granted until the UART
// programmer reports completion.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   upg_done_i                    programming finished (0 blocks all grants)
//   if_req/if_addr                fetch request (read only)
//   if_gnt/if_rvalid/if_rdata     fetch grant and read return
//   d_req/d_we/d_size/d_addr/d_wdata  load/store request
//   d_gnt/d_err/d_rvalid/d_rdata  data grant, misalign error, load return
//   mem_addr/mem_we/mem_size/mem_wdata  muxed access to the bridge
//   mem_rdata                     bridge read data, MEM_LAT cycles after address
module riscv_mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upg_done_i,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_err,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]         starve_cnt;
  logic               fetch_win;
  logic               data_win;
  logic               d_misalign;
  logic               rd_issue;
  // Tag stage i: valid read in flight, owner 0 = fetch, 1 = data.
  logic [MEM_LAT-1:0] tag_v;
  logic [MEM_LAT-1:0] tag_own;

  always_comb begin
    case (d_size)
      2'b00:   d_misalign = 1'b0;
      2'b01:   d_misalign = d_addr[0];
      default: d_misalign = |d_addr[1:0];  // 11 behaves as word
    endcase
  end

  assign fetch_win = upg_done_i & if_req & (~d_req | (starve_cnt == STARVE_LIM));
  assign data_win  = upg_done_i & d_req & ~fetch_win;

  assign if_gnt = fetch_win;
  assign d_gnt  = data_win;
  assign d_err  = data_win & d_misalign;

  // Misaligned loads are still granted but must not produce a return.
  assign rd_issue = fetch_win | (data_win & ~d_we & ~d_misalign);

  always_comb begin
    mem_addr  = 32'h0;
    mem_we    = 1'b0;
    mem_size  = 2'b10;
    mem_wdata = 32'h0;
    if (fetch_win) begin
      mem_addr = if_addr;
    end else if (data_win) begin
      mem_addr  = d_addr;
      mem_we    = d_we & ~d_misalign;
      mem_size  = d_size;
      mem_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!if_req || fetch_win) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v   <= '0;
      tag_own <= '0;
    end else begin
      tag_v[0]   <= rd_issue;
      tag_own[0] <= data_win;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_own[i] <= tag_own[i-1];
      end
    end
  end

  assign if_rvalid = tag_v[MEM_LAT-1] & ~tag_own[MEM_LAT-1];
  assign d_rvalid  = tag_v[MEM_LAT-1] &  tag_own[MEM_LAT-1];
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rdata   = d_rvalid  ? mem_rdata : 32'h0;

endmodule
